// File: rtl/tile_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tile_engine
//  Function : Piano Tiles game core: falling tile column, key judging, score
//             and a registered per-pixel tile_on flag for the VGA path.
//  Revision : 1.0 - initial release
// ============================================================================
module tile_engine #(
    parameter int          TILE_W     = 160,
    parameter int          TILE_H     = 120,
    parameter int          ROWS       = 5,
    parameter int          SPEED_INIT = 2,
    parameter int          SPEED_MAX  = 8,
    parameter int          SPEED_STEP = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] key,
    input  logic [9:0] x_loc,
    input  logic [9:0] y_loc,
    input  logic       video_on,
    output logic [9:0] score,
    output logic       tile_on,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0]  c_st_idle    = 2'b00;
    localparam logic [1:0]  c_st_play    = 2'b01;
    localparam logic [1:0]  c_st_over    = 2'b10;
    localparam int          c_idx_w      = $clog2(ROWS);
    localparam int          c_screen_h   = 480;
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;
    localparam logic [7:0]  c_tile_h     = 8'(TILE_H);
    localparam logic [7:0]  c_speed_init = 8'(SPEED_INIT);
    localparam logic [7:0]  c_speed_max  = 8'(SPEED_MAX);
    localparam logic [7:0]  c_speed_step = 8'(SPEED_STEP);
    localparam logic [9:0]  c_score_max  = 10'd999;
    localparam logic [10:0] c_tile_w     = 11'(TILE_W);

    logic [1:0]          r_state, w_state_nx;
    logic [9:0]          r_score, w_score_nx;
    logic [7:0]          r_off, w_off_nx, r_speed, w_speed_nx, r_step, w_step_nx, w_sum;
    logic [2*ROWS-1:0]   r_lanes, w_lanes_nx;
    logic [ROWS-1:0]     r_hit, w_hit_nx;
    logic [15:0]         r_lfsr, w_lfsr_nx;
    logic                r_tile_on, r_game_over;
    logic [1:0]          w_lane [ROWS];
    logic [ROWS-1:0]     w_in_row;
    logic                w_tile_nx, w_found, w_fail;
    logic [c_idx_w-1:0]  w_target;
    logic [1:0]          w_target_lane;
    logic signed [10:0]  w_y_s, w_off_s;
    logic [10:0]         w_x_u;

    assign w_y_s = $signed({1'b0, y_loc});
    assign w_off_s = $signed({3'b000, r_off});
    assign w_x_u = {1'b0, x_loc};

    // Per-row pixel hit test; row bounds are signed so the entering row may start above the screen
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic signed [10:0] w_top, w_bot;
        logic [10:0]        w_left;
        assign w_lane[gi]   = r_lanes[2*gi +: 2];
        assign w_top        = $signed(11'(c_screen_h - (gi + 1) * TILE_H)) + w_off_s;
        assign w_bot        = w_top + $signed(11'(TILE_H));
        assign w_left       = 11'(w_lane[gi]) * c_tile_w;
        assign w_in_row[gi] = !r_hit[gi] && (w_y_s >= w_top) && (w_y_s < w_bot)
                              && (w_x_u >= w_left) && (w_x_u < w_left + c_tile_w);
    end

    assign w_tile_nx = (r_state != c_st_idle) && video_on && (y_loc < 10'(c_screen_h)) && (|w_in_row);

    always_comb begin
        w_found       = 1'b0;
        w_target      = '0;
        w_target_lane = 2'b00;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r_hit[i]) begin
                w_found       = 1'b1;
                w_target      = c_idx_w'(i);
                w_target_lane = w_lane[i];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_score_nx = r_score;
        w_off_nx   = r_off;
        w_speed_nx = r_speed;
        w_step_nx  = r_step;
        w_lanes_nx = r_lanes;
        w_hit_nx   = r_hit;
        w_lfsr_nx  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
        w_sum      = r_off + r_speed;
        w_fail     = 1'b0;
        case (r_state)
            c_st_idle, c_st_over: begin
                if (start) begin
                    w_state_nx = c_st_play;
                    w_score_nx = '0;
                    w_off_nx   = '0;
                    w_speed_nx = c_speed_init;
                    w_step_nx  = '0;
                    w_lanes_nx = r_lfsr[2*ROWS-1:0];
                    w_hit_nx   = '0;
                end
            end
            c_st_play: begin
                if (key != 4'b0000) begin
                    if (w_found && (key == (4'b0001 << w_target_lane))) begin
                        w_hit_nx[w_target] = 1'b1;
                        if (r_score != c_score_max) w_score_nx = r_score + 10'd1;
                        if (r_step + 8'd1 >= c_speed_step) begin
                            w_step_nx = '0;
                            if (r_speed < c_speed_max) w_speed_nx = r_speed + 8'd1;
                        end else begin
                            w_step_nx = r_step + 8'd1;
                        end
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                // Scroll sees this cycle's hit flags, so a hit on the bottom row saves it
                if (frame_tick && !w_fail) begin
                    if (w_sum < c_tile_h) begin
                        w_off_nx = w_sum;
                    end else if (!w_hit_nx[0]) begin
                        w_fail = 1'b1;
                    end else begin
                        w_off_nx   = w_sum - c_tile_h;
                        w_lanes_nx = {r_lfsr[1:0], r_lanes[2*ROWS-1:2]};
                        w_hit_nx   = {1'b0, w_hit_nx[ROWS-1:1]};
                    end
                end
                if (w_fail) w_state_nx = c_st_over;
            end
            default: w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_score     <= '0;
            r_off       <= '0;
            r_speed     <= c_speed_init;
            r_step      <= '0;
            r_lanes     <= '0;
            r_hit       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_tile_on   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_score     <= w_score_nx;
            r_off       <= w_off_nx;
            r_speed     <= w_speed_nx;
            r_step      <= w_step_nx;
            r_lanes     <= w_lanes_nx;
            r_hit       <= w_hit_nx;
            r_lfsr      <= w_lfsr_nx;
            r_tile_on   <= w_tile_nx;
            r_game_over <= (w_state_nx == c_st_over);
        end
    end

    assign score     = r_score;
    assign tile_on   = r_tile_on;
    assign game_over = r_game_over;
    assign state     = r_state;

endmodule
`default_nettype wire
